// File: rtl/regfile_sync_param_pkg.sv
// Shared register-file definitions: clear-engine states and the default
// geometry that the decode stage also relies on.
package regfile_pkg;

    localparam int DefaultWidth = 16;
    localparam int DefaultDepth = 32;
    localparam int DefaultAddrW = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clrState_e;

endpackage

// File: rtl/regfile_sync_param_if.sv
// Register-file access bus: one write port, two read ports, bulk clear.
// The master is the decode stage; the slave is the register file.
interface regfile_sync_param_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DefaultWidth,
    parameter int ADDR_W = DefaultAddrW
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              wr_ready;
    logic              rd_en1;
    logic [ADDR_W-1:0] rd_addr1;
    logic [WIDTH-1:0]  rd_data1;
    logic              rd_valid1;
    logic              rd_en2;
    logic [ADDR_W-1:0] rd_addr2;
    logic [WIDTH-1:0]  rd_data2;
    logic              rd_valid2;
    logic              clr_req;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en1, rd_addr1, rd_en2, rd_addr2, clr_req,
        input  wr_ready, rd_data1, rd_valid1, rd_data2, rd_valid2, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en1, rd_addr1, rd_en2, rd_addr2, clr_req,
        output wr_ready, rd_data1, rd_valid1, rd_data2, rd_valid2, busy
    );
endinterface

// File: rtl/regfile_sync_param_read_port.sv
// One registered read port: range check, hardwired-zero register,
// optional forwarding of the write landing this cycle, and a valid flop.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DefaultWidth,
    parameter int DEPTH    = DefaultDepth,
    parameter int ADDR_W   = DefaultAddrW,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic [WIDTH-1:0]  memData,
    input  logic              wrFire,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WIDTH-1:0]  wrData,
    output logic [WIDTH-1:0]  rdData,
    output logic              rdValid
);

    logic [WIDTH-1:0] nextData;

    // Select what the read returns at the coming edge.
    always_comb begin
        nextData = memData;
        if (int'(rdAddr) >= DEPTH) begin
            nextData = '0;
        end else if (ZERO_REG != 0 && rdAddr == '0) begin
            nextData = '0;
        end else if (BYPASS != 0 && wrFire && wrAddr == rdAddr) begin
            nextData = wrData;
        end
    end

    // Register the data on a request; hold it otherwise. Valid lasts one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= rdEn;
            if (rdEn) begin
                rdData <= nextData;
            end
        end
    end

endmodule

// File: rtl/regfile_sync_param.sv
// Clocked register file with one write port, two registered read ports,
// optional write-to-read bypass, optional zero register and a bulk-clear engine.
module regfile_sync_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DefaultWidth,
    parameter int DEPTH    = DefaultDepth,
    parameter int ADDR_W   = DefaultAddrW,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_sync_param_if.slave  bus
);

    localparam int unsigned       Slots   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [Slots];
    clrState_e         state;
    logic [ADDR_W-1:0] clrCnt;
    logic              busyQ;
    logic              wrReady;
    logic              wrKeep;
    logic              memWe;
    logic [ADDR_W-1:0] memWa;
    logic [WIDTH-1:0]  memWd;
    logic [WIDTH-1:0]  rdData1;
    logic [WIDTH-1:0]  rdData2;
    logic              rdValid1;
    logic              rdValid2;

    assign wrKeep = bus.wr_en && wrReady && (int'(bus.wr_addr) < DEPTH)
                    && !(ZERO_REG != 0 && bus.wr_addr == '0);

    // Clear steps share the single storage write port (wr_ready is low while
    // clearing), so the read ports see the zeroing as an ordinary write.
    always_comb begin
        memWe = wrKeep;
        memWa = bus.wr_addr;
        memWd = bus.wr_data;
        if (state == CLEAR) begin
            memWe = 1'b1;
            memWa = clrCnt;
            memWd = '0;
        end
    end

    // Storage array update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (memWe) begin
            mem[memWa] <= memWd;
        end
    end

    // Clear sequencer: zero one register per cycle from index 0 to DEPTH-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            clrCnt  <= '0;
            busyQ   <= 1'b0;
            wrReady <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state   <= CLEAR;
                        clrCnt  <= '0;
                        busyQ   <= 1'b1;
                        wrReady <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clrCnt == LastIdx) begin
                        state   <= IDLE;
                        clrCnt  <= '0;
                        busyQ   <= 1'b0;
                        wrReady <= 1'b1;
                    end else begin
                        clrCnt <= clrCnt + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    regfile_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) readPort1 (
        .clk(clk), .rst_n(rst_n),
        .rdEn(bus.rd_en1), .rdAddr(bus.rd_addr1), .memData(mem[bus.rd_addr1]),
        .wrFire(memWe), .wrAddr(memWa), .wrData(memWd),
        .rdData(rdData1), .rdValid(rdValid1)
    );

    regfile_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) readPort2 (
        .clk(clk), .rst_n(rst_n),
        .rdEn(bus.rd_en2), .rdAddr(bus.rd_addr2), .memData(mem[bus.rd_addr2]),
        .wrFire(memWe), .wrAddr(memWa), .wrData(memWd),
        .rdData(rdData2), .rdValid(rdValid2)
    );

    assign bus.rd_data1  = rdData1;
    assign bus.rd_valid1 = rdValid1;
    assign bus.rd_data2  = rdData2;
    assign bus.rd_valid2 = rdValid2;
    assign bus.wr_ready  = wrReady;
    assign bus.busy      = busyQ;

endmodule
